// File: rtl/tsqr_r_readback.sv
`default_nettype none
// ============================================================================
// Module   : tsqr_r_readback
// Brief    : Reads the TSQR triangular result (R) rows over DMA port B after
//            tsqr_fi and streams them out on a valid/ready row interface.
//            Optional lower-triangle masking: define TSQR_RB_TRI_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tsqr_r_readback #(
    parameter int RAM_WIDTH      = 256,
    parameter int ELEM_W         = 64,
    parameter int MATRIX_WIDTH   = 4,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int MEM_NO         = 2,
    parameter int MEM_SEL        = 0,
    parameter int BASE_ADDR      = 0,
    parameter int RD_LAT         = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tsqr_fi,
    output logic [MEM_NO-1:0]               dma_mem_enb,
    output logic [RAM_ADDR_WIDTH-1:0]       dma_mem_addrb,
    input  logic [RAM_WIDTH-1:0]            dma_mem_doutb,
    output logic                            r_valid,
    input  logic                            r_ready,
    output logic [RAM_WIDTH-1:0]            r_data,
    output logic [$clog2(MATRIX_WIDTH)-1:0] r_row,
    output logic                            r_last,
    output logic                            busy,
    output logic                            done,
    output logic                            err_overrun
);

    localparam int C_FIFO_DEPTH = RD_LAT + 1;
    localparam int C_PTR_W      = $clog2(C_FIFO_DEPTH);
    localparam int C_CNT_W      = $clog2(C_FIFO_DEPTH + 1);
    localparam int C_ROW_W      = $clog2(MATRIX_WIDTH);
    localparam int C_ISS_W      = $clog2(MATRIX_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_fi_d;
    logic                       r_err;
    logic [C_ISS_W-1:0]         r_iss_cnt;
    logic [RAM_ADDR_WIDTH-1:0]  r_addr_hold;
    logic [RD_LAT-1:0]          r_tag_v;
    logic [C_ROW_W-1:0]         r_tag_row [RD_LAT];
    logic [RAM_WIDTH-1:0]       r_fifo_data [C_FIFO_DEPTH];
    logic [C_ROW_W-1:0]         r_fifo_row [C_FIFO_DEPTH];
    logic [C_PTR_W-1:0]         r_wr_ptr;
    logic [C_PTR_W-1:0]         r_rd_ptr;
    logic [C_CNT_W-1:0]         r_fifo_cnt;

    logic                       w_rise;
    logic                       w_issue;
    logic                       w_wr;
    logic                       w_pop;
    logic [C_CNT_W-1:0]         w_in_flight;
    logic [C_CNT_W:0]           w_committed;
    logic [RAM_ADDR_WIDTH-1:0]  w_issue_addr;
    logic [C_ROW_W-1:0]         w_out_row;
    logic [RAM_WIDTH-1:0]       w_out_raw;

    assign w_rise       = tsqr_fi & ~r_fi_d;
    assign w_issue_addr = RAM_ADDR_WIDTH'(BASE_ADDR) + RAM_ADDR_WIDTH'(r_iss_cnt);
    assign w_wr         = r_tag_v[RD_LAT-1];
    assign w_pop        = r_valid & r_ready;

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_in_flight = w_in_flight + C_CNT_W'(r_tag_v[i]);
        end
    end

    // A pop this cycle frees a slot, so back-to-back issue is sustained with r_ready high
    assign w_committed = {1'b0, w_in_flight} + {1'b0, r_fifo_cnt} - (C_CNT_W + 1)'(w_pop);
    assign w_issue     = (r_state == S_READ) && (w_committed < (C_CNT_W + 1)'(C_FIFO_DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_READ;
            S_READ:  if (w_issue && (r_iss_cnt == C_ISS_W'(MATRIX_WIDTH - 1))) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pop && r_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fi_d      <= 1'b0;
            r_err       <= 1'b0;
            r_iss_cnt   <= '0;
            r_addr_hold <= '0;
            r_tag_v     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_row[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_fi_d  <= tsqr_fi;
            r_err   <= w_rise && (r_state != S_IDLE);
            if (r_state != S_READ) begin
                r_iss_cnt <= '0;
            end else if (w_issue) begin
                r_iss_cnt <= r_iss_cnt + C_ISS_W'(1);
            end
            if (w_issue) begin
                r_addr_hold <= w_issue_addr;
            end
            r_tag_v[0]   <= w_issue;
            r_tag_row[0] <= r_iss_cnt[C_ROW_W-1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_row[i] <= r_tag_row[i-1];
            end
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_W'(C_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_W'(C_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + C_CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - C_CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_fifo_data[r_wr_ptr] <= dma_mem_doutb;
            r_fifo_row[r_wr_ptr]  <= r_tag_row[RD_LAT-1];
        end
    end

    assign r_valid   = (r_fifo_cnt != '0);
    assign w_out_row = r_valid ? r_fifo_row[r_rd_ptr] : '0;
    assign w_out_raw = r_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign r_row     = w_out_row;
    assign r_last    = r_valid && (w_out_row == C_ROW_W'(MATRIX_WIDTH - 1));

`ifdef TSQR_RB_TRI_MASK_EN
    for (genvar k = 0; k < MATRIX_WIDTH; k++) begin : g_tri_mask
        assign r_data[RAM_WIDTH-1-k*ELEM_W -: ELEM_W] =
            (C_ROW_W'(k) < w_out_row) ? '0 : w_out_raw[RAM_WIDTH-1-k*ELEM_W -: ELEM_W];
    end
`else
    assign r_data = w_out_raw;
`endif

    assign dma_mem_enb   = w_issue ? (MEM_NO'(1) << MEM_SEL) : '0;
    assign dma_mem_addrb = w_issue ? w_issue_addr : r_addr_hold;
    assign busy          = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done          = (r_state == S_DONE);
    assign err_overrun   = r_err;

endmodule
`default_nettype wire
